// File: rtl/row_pair_packer.sv
// row_pair_packer
//
// Front end of the row DWT stage. This block takes a serial stream of
// unsigned pixels, one per beat. It converts each pixel to a signed
// fixed-point sample and packs consecutive samples into {odd, even} pairs.
// An odd-length row is completed by a whole-sample symmetric pad, so the
// downstream lifting pipeline only ever receives complete pairs. The sof and
// eol flags are regenerated for each output pair.
//
// Optional feature macro: ROW_PAIR_PACKER_LEVEL_SHIFT_EN
//   defined   -> subtract 2^(PixelWidth-1) before scaling (DC level shift)
//   undefined -> zero-extend and scale only (non-negative outputs)
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   s_ready_o  input ready (combinational from m_ready_i)
//   s_valid_i  input sample valid
//   s_sof_i    first sample of frame
//   s_eol_i    last sample of row
//   s_data_i   unsigned pixel, PixelWidth bits
//   m_ready_i  output ready
//   m_valid_o  output pair valid
//   m_sof_o    first pair of frame
//   m_eol_o    last pair of row
//   m_data_o   {odd, even}, even sample in the low DataWidth bits

module row_pair_packer #(
  parameter int DataWidth  = 16,
  parameter int PixelWidth = 8,
  parameter int FracBits   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [PixelWidth-1:0]  s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  // The converted sample must fit: pixel bits, one sign bit, and the shift.
  generate
    if (PixelWidth + 1 + FracBits > DataWidth) begin : g_width_check
      $error("row_pair_packer: PixelWidth + 1 + FracBits must be <= DataWidth");
    end
  endgenerate

  typedef enum logic [0:0] {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  // Pixel to fixed-point conversion. The result always fits in DataWidth
  // bits, so the left shift cannot lose significant bits.
  function automatic logic [DataWidth-1:0] conv(input logic [PixelWidth-1:0] x);
    logic [PixelWidth:0]  z;
    logic [DataWidth-1:0] w;
    z = {1'b0, x};
`ifdef ROW_PAIR_PACKER_LEVEL_SHIFT_EN
    z = z - {2'b01, {(PixelWidth-1){1'b0}}};
`endif
    w = {{(DataWidth-PixelWidth-1){z[PixelWidth]}}, z};
    conv = w << FracBits;
  endfunction

  state_t               state;
  logic [DataWidth-1:0] even_q;
  logic [DataWidth-1:0] last_odd_q;
  logic                 sof_q;
  logic                 row_first_q;

  logic                 in_xfer;
  logic                 out_xfer;
  logic [DataWidth-1:0] sample;
  logic [DataWidth-1:0] pad;

  // Handshake terms and the converted sample of the current input beat.
  always_comb begin
    s_ready_o = !m_valid_o | m_ready_i;
    in_xfer   = s_valid_i & s_ready_o;
    out_xfer  = m_valid_o & m_ready_i;
    sample    = conv(s_data_i);
    // A one-sample row mirrors itself. Otherwise the pad is x[N-2].
    if (row_first_q) begin
      pad = sample;
    end else begin
      pad = last_odd_q;
    end
  end

  // Pairing FSM with its registered output pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EVEN;
      even_q      <= {DataWidth{1'b0}};
      last_odd_q  <= {DataWidth{1'b0}};
      sof_q       <= 1'b0;
      row_first_q <= 1'b1;
      m_valid_o   <= 1'b0;
      m_sof_o     <= 1'b0;
      m_eol_o     <= 1'b0;
      m_data_o    <= {(2*DataWidth){1'b0}};
    end else begin
      // When a pair is consumed, m_valid_o is cleared. A pair loaded in
      // the same cycle (below) overrides this.
      if (out_xfer) begin
        m_valid_o <= 1'b0;
      end
      if (in_xfer) begin
        case (state)
          EVEN: begin
            if (s_eol_i) begin
              m_data_o    <= {pad, sample};
              m_valid_o   <= 1'b1;
              m_sof_o     <= s_sof_i;
              m_eol_o     <= 1'b1;
              row_first_q <= 1'b1;
              state       <= EVEN;
            end else begin
              even_q <= sample;
              sof_q  <= s_sof_i;
              state  <= ODD;
            end
          end
          ODD: begin
            if (s_sof_i) begin
              // Frame restart mid-pair: the held even sample is discarded,
              // and this beat is handled as if it arrived in EVEN.
              row_first_q <= 1'b1;
              if (s_eol_i) begin
                m_data_o  <= {sample, sample};
                m_valid_o <= 1'b1;
                m_sof_o   <= 1'b1;
                m_eol_o   <= 1'b1;
                state     <= EVEN;
              end else begin
                even_q <= sample;
                sof_q  <= 1'b1;
                state  <= ODD;
              end
            end else begin
              m_data_o    <= {sample, even_q};
              m_valid_o   <= 1'b1;
              m_sof_o     <= sof_q;
              m_eol_o     <= s_eol_i;
              last_odd_q  <= sample;
              row_first_q <= s_eol_i;
              state       <= EVEN;
            end
          end
          default: begin
            state <= EVEN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_pair_packer.sv
// Self-checking bench for row_pair_packer. Each comparison checks the packed
// word {m_valid_o, m_sof_o, m_eol_o, m_data_o} or a single flag. The
// expected value is hand-computed for the default parameters (8-bit pixels,
// FracBits 4). It follows the build's level-shift setting.

module tb_row_pair_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_ready;
  logic        s_valid;
  logic        s_sof;
  logic        s_eol;
  logic [7:0]  s_data;
  logic        m_ready;
  logic        m_valid;
  logic        m_sof;
  logic        m_eol;
  logic [31:0] m_data;

  int checks   = 0;
  int failures = 0;

`ifdef ROW_PAIR_PACKER_LEVEL_SHIFT_EN
  localparam logic [15:0] C1   = 16'hF810;
  localparam logic [15:0] C2   = 16'hF820;
  localparam logic [15:0] C3   = 16'hF830;
  localparam logic [15:0] C4   = 16'hF840;
  localparam logic [15:0] C6   = 16'hF860;
  localparam logic [15:0] C7   = 16'hF870;
  localparam logic [15:0] C9   = 16'hF890;
  localparam logic [15:0] C10  = 16'hF8A0;
  localparam logic [15:0] C20  = 16'hF940;
  localparam logic [15:0] C30  = 16'hF9E0;
  localparam logic [15:0] C40  = 16'hFA80;
  localparam logic [15:0] C255 = 16'h07F0;
`else
  localparam logic [15:0] C1   = 16'h0010;
  localparam logic [15:0] C2   = 16'h0020;
  localparam logic [15:0] C3   = 16'h0030;
  localparam logic [15:0] C4   = 16'h0040;
  localparam logic [15:0] C6   = 16'h0060;
  localparam logic [15:0] C7   = 16'h0070;
  localparam logic [15:0] C9   = 16'h0090;
  localparam logic [15:0] C10  = 16'h00A0;
  localparam logic [15:0] C20  = 16'h0140;
  localparam logic [15:0] C30  = 16'h01E0;
  localparam logic [15:0] C40  = 16'h0280;
  localparam logic [15:0] C255 = 16'h0FF0;
`endif

  row_pair_packer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_ready_o (s_ready),
    .s_valid_i (s_valid),
    .s_sof_i   (s_sof),
    .s_eol_i   (s_eol),
    .s_data_i  (s_data),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_sof_o   (m_sof),
    .m_eol_o   (m_eol),
    .m_data_o  (m_data)
  );

  always #5 clk = ~clk;

  // One input beat. The caller must make sure s_ready is high.
  task automatic beat(input logic [7:0] d, input logic sof, input logic eol);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== 35'd0) begin
      $display("FAIL reset_outputs got=%h exp=0", {m_valid, m_sof, m_eol, m_data});
      failures++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      $display("FAIL reset_s_ready got=%b exp=1", s_ready);
      failures++;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_even_row;
    m_ready = 1'b1;
    beat(8'd10, 1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      $display("FAIL even_first_no_out got=%b exp=0", m_valid);
      failures++;
    end
    beat(8'd20, 1'b0, 1'b0);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b110, C20, C10}) begin
      $display("FAIL even_pair0 got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b110, C20, C10});
      failures++;
    end
    beat(8'd30, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      $display("FAIL even_valid_cleared got=%b exp=0", m_valid);
      failures++;
    end
    beat(8'd40, 1'b0, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b101, C40, C30}) begin
      $display("FAIL even_pair1 got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b101, C40, C30});
      failures++;
    end
  endtask

  task automatic test_odd_row;
    beat(8'd1, 1'b1, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b110, C2, C1}) begin
      $display("FAIL odd_pair0 got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b110, C2, C1});
      failures++;
    end
    beat(8'd3, 1'b0, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b101, C2, C3}) begin
      $display("FAIL odd_pad_pair got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b101, C2, C3});
      failures++;
    end
  endtask

  // This row follows an odd row, so a stale last_odd pad would show here.
  task automatic test_single;
    beat(8'd255, 1'b1, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b111, C255, C255}) begin
      $display("FAIL single_pair got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b111, C255, C255});
      failures++;
    end
  endtask

  task automatic test_backpressure;
    m_ready = 1'b1;
    beat(8'd10, 1'b1, 1'b0);
    m_ready = 1'b0;
    beat(8'd20, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'd30;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_valid, m_sof, m_eol, m_data, s_ready} !== {3'b110, C20, C10, 1'b0}) begin
        $display("FAIL bp_hold%0d got=%h exp=%h", i, {m_valid, m_sof, m_eol, m_data, s_ready},
                 {3'b110, C20, C10, 1'b0});
        failures++;
      end
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      $display("FAIL bp_ready_comb got=%b exp=1", s_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      $display("FAIL bp_drained got=%b exp=0", m_valid);
      failures++;
    end
    beat(8'd40, 1'b0, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b101, C40, C30}) begin
      $display("FAIL bp_resume got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b101, C40, C30});
      failures++;
    end
  endtask

  task automatic test_sof_restart;
    beat(8'd5, 1'b1, 1'b0);
    beat(8'd7, 1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      $display("FAIL restart_no_out got=%b exp=0", m_valid);
      failures++;
    end
    beat(8'd9, 1'b0, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b111, C9, C7}) begin
      $display("FAIL restart_pair got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b111, C9, C7});
      failures++;
    end
    beat(8'd5, 1'b1, 1'b0);
    beat(8'd6, 1'b1, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b111, C6, C6}) begin
      $display("FAIL restart_eol_pad got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b111, C6, C6});
      failures++;
    end
  endtask

  task automatic test_async_reset;
    // First case: a valid pair is pending and held by backpressure.
    m_ready = 1'b1;
    beat(8'd10, 1'b1, 1'b0);
    m_ready = 1'b0;
    beat(8'd20, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== 35'd0) begin
      $display("FAIL arst_pair_dropped got=%h exp=0", {m_valid, m_sof, m_eol, m_data});
      failures++;
    end
    #2;
    rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    // Second case: an even sample is held. Reset must drop it.
    beat(8'd30, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== 35'd0) begin
      $display("FAIL arst_even_held got=%h exp=0", {m_valid, m_sof, m_eol, m_data});
      failures++;
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat(8'd3, 1'b1, 1'b0);
    beat(8'd4, 1'b0, 1'b1);
    checks++;
    if ({m_valid, m_sof, m_eol, m_data} !== {3'b111, C4, C3}) begin
      $display("FAIL arst_repack got=%h exp=%h", {m_valid, m_sof, m_eol, m_data}, {3'b111, C4, C3});
      failures++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    s_data  = 8'd0;
    m_ready = 1'b1;
    test_reset();
    test_even_row();
    test_odd_row();
    test_single();
    test_backpressure();
    test_sof_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
